// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory BIST controller and its checker.
package mem_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int ERR_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } bist_state_t;

  typedef enum logic [1:0] {
    PAT_CLR  = 2'd0,
    PAT_ADDR = 2'd1,
    PAT_INV  = 2'd2
  } bist_pat_t;

  // Word written/expected at address a; callers truncate to their data width.
  function automatic logic [31:0] exp_data(bist_pat_t pat, logic [31:0] a);
    case (pat)
      PAT_CLR:  return '0;
      PAT_ADDR: return a;
      PAT_INV:  return ~a;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/mem_bist_chk.sv
// Read-back checker: registers the expected word at issue, compares one cycle
// later, keeps a saturating error count and the first failing address.
module mem_bist_chk
  import mem_pkg::*;
#(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int ERR_W  = mem_pkg::ERR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] exp_word,
  input  logic [DATA_W-1:0] data_out,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] exp_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      valid_q   <= 1'b0;
      addr_q    <= '0;
      exp_q     <= '0;
      err_count <= '0;
      fail_addr <= '0;
    end else begin
      valid_q <= en;
      if (en) begin
        addr_q <= addr;
        exp_q  <= exp_word;
      end
      if (valid_q && (data_out != exp_q)) begin
        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
        // A saturating count never returns to zero, so zero marks the first miss.
        if (err_count == '0) fail_addr <= addr_q;
      end
    end
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// BIST sequencer for the 32x8 single-port memory: clear, address and
// inverted-address patterns, each written in full and then read back.
//
// state   | meaning
// IDLE    | waiting for start, no memory access
// WRITE   | writing the current pattern, one address per cycle
// READ    | reading the pattern back, one address per cycle
// DRAIN   | no access; the last read of the pattern is compared
// DONE    | results held until the next start
module mem_bist_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int ERR_W  = mem_pkg::ERR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  bist_state_t       state;
  bist_pat_t         pat;
  bist_pat_t         pat_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] exp_word;
  logic              accept;

  assign addr_nxt = addr + 1'b1;
  assign pat_nxt  = (pat == PAT_CLR) ? PAT_ADDR : PAT_INV;
  assign exp_word = DATA_W'(exp_data(pat, 32'(addr)));
  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign pass     = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pat     <= PAT_CLR;
      addr    <= '0;
      read    <= 1'b0;
      write   <= 1'b0;
      data_in <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_WRITE;
            pat     <= PAT_CLR;
            addr    <= '0;
            write   <= 1'b1;
            read    <= 1'b0;
            data_in <= DATA_W'(exp_data(PAT_CLR, 32'd0));
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_WRITE: begin
          if (addr == ADDR_LAST) begin
            state <= S_READ;
            write <= 1'b0;
            read  <= 1'b1;
            addr  <= '0;
          end else begin
            addr    <= addr_nxt;
            data_in <= DATA_W'(exp_data(pat, 32'(addr_nxt)));
          end
        end
        S_READ: begin
          if (addr == ADDR_LAST) begin
            state <= S_DRAIN;
            read  <= 1'b0;
            addr  <= '0;
          end else begin
            addr <= addr_nxt;
          end
        end
        S_DRAIN: begin
          if (pat == PAT_INV) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state   <= S_WRITE;
            pat     <= pat_nxt;
            write   <= 1'b1;
            data_in <= DATA_W'(exp_data(pat_nxt, 32'd0));
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mem_bist_chk #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .ERR_W (ERR_W)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .en       (read),
    .addr     (addr),
    .exp_word (exp_word),
    .data_out (data_out),
    .err_count(err_count),
    .fail_addr(fail_addr)
  );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl against a behavioural 32x8 memory with
// selectable read faults.
module tb_mem_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass, read, write;
  logic [5:0] err_count;
  logic [4:0] fail_addr, addr;
  logic [7:0] data_in, data_out;

  int checks = 0;
  int failures = 0;

  // 0 healthy, 1 data_out[0] stuck-at-0, 2 data_out forced 0xFF, 3 addr 0x13 inverted
  int         mode = 0;
  logic [7:0] mem [32];
  logic [7:0] rd_q = 8'h00;
  logic [4:0] rd_addr_q = 5'h00;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write) mem[addr] <= data_in;
    if (read) begin
      rd_q      <= mem[addr];
      rd_addr_q <= addr;
    end
  end

  always_comb begin
    data_out = rd_q;
    case (mode)
      1: data_out = rd_q & 8'hFE;
      2: data_out = 8'hFF;
      3: data_out = (rd_addr_q == 5'h13) ? ~rd_q : rd_q;
      default: data_out = rd_q;
    endcase
  end

  mem_bist_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_addr(fail_addr),
    .addr     (addr),
    .read     (read),
    .write    (write),
    .data_in  (data_in),
    .data_out (data_out)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [7:0] pat_word(input int p, input int a);
    logic [7:0] av;
    av = 8'(a);
    case (p)
      0: return 8'h00;
      1: return av;
      default: return ~av;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_count), 0);
    check({tag, "_fail_addr"}, int'(fail_addr), 0);
    check({tag, "_bus"}, int'({addr, read, write, data_in}), 0);
  endtask

  // Pulses start, then follows the run cycle by cycle. cyc is the cycle index
  // after the start edge at which done was first seen (-1 if aborted/timeout).
  task automatic run(input string tag, input int rst_at, input bit extra_starts,
                     output int cyc, output int nwr, output int nrd, output int bad);
    int n;
    nwr = 0; nrd = 0; bad = 0; cyc = -1;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    check({tag, "_t1_write"}, int'(write), 1);
    check({tag, "_t1_busy_done"}, int'({busy, done}), 2);
    check({tag, "_t1_err_cleared"}, int'(err_count), 0);
    for (;;) begin
      if (write && read) bad++;
      if (!busy && (write || read)) bad++;
      if (write) begin
        if (int'(addr) != nwr % 32) bad++;
        if (data_in != pat_word(nwr / 32, nwr % 32)) bad++;
        nwr++;
      end
      if (read) begin
        if (int'(addr) != nrd % 32) bad++;
        nrd++;
      end
      if (done) begin
        cyc = n;
        break;
      end
      if (n >= 400) begin
        check({tag, "_timeout"}, n, 196);
        break;
      end
      start = extra_starts && (n == 10 || n == 100);
      if (n == rst_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_all_zero({tag, "_rst"});
        @(posedge clk); #1;
        check({tag, "_rst_no_pending_err"}, int'(err_count), 0);
        check({tag, "_rst_idle"}, int'({busy, write, read}), 0);
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
  endtask

  task automatic full_run(input string tag, input bit extra_starts, input int exp_err,
                          input int exp_fail, input int exp_pass);
    int cyc, nwr, nrd, bad;
    run(tag, 0, extra_starts, cyc, nwr, nrd, bad);
    check({tag, "_done_cycle"}, cyc, 196);
    check({tag, "_write_cycles"}, nwr, 96);
    check({tag, "_read_cycles"}, nrd, 96);
    check({tag, "_bus_seq_errs"}, bad, 0);
    check({tag, "_err_count"}, int'(err_count), exp_err);
    check({tag, "_fail_addr"}, int'(fail_addr), exp_fail);
    check({tag, "_pass"}, int'(pass), exp_pass);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int cyc, nwr, nrd, bad;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_access", int'({busy, write, read}), 0);

    mode = 0; full_run("healthy", 1'b0, 0, 0, 1);
    repeat (5) @(posedge clk);
    #1;
    check("done_held", int'({done, pass}), 3);

    mode = 1; full_run("stuck0", 1'b0, 32, 5'h01, 0);
    mode = 0; full_run("restart", 1'b0, 0, 0, 1);
    mode = 2; full_run("force_ff", 1'b0, 63, 5'h00, 0);
    mode = 3; full_run("addr13", 1'b0, 3, 5'h13, 0);

    mode = 2;
    run("midrst", 50, 1'b0, cyc, nwr, nrd, bad);
    check("midrst_bus_seq_errs", bad, 0);
    mode = 0; full_run("after_rst", 1'b0, 0, 0, 1);

    full_run("ignored_start", 1'b1, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bist_ctrl.md
# mem_bist_ctrl

Synthesizable built-in self-test controller sitting directly upstream of the 32x8 single-port memory: it drives the memory's `addr`/`read`/`write`/`data_in` and consumes `data_out`. On `start` it runs three write-then-read-back patterns: clear, data = address, data = ~address. It compares every read word, counts mismatches and records the first failing address. It replaces the behavioural memory test sequence in silicon-level runs and reports a single pass/fail to the system.

## Interface
- `ADDR_W`, 5, memory address width (depth = 2**ADDR_W)
- `DATA_W`, 8, memory data width
- `ERR_W`, 6, error counter width; saturates at 2**ERR_W-1

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle request to begin a test run
- `busy`  out  1  run in progress
- `done`  out  1  run complete; held until next accepted `start` or reset
- `pass`  out  1  `done` and `err_count`==0
- `err_count`  out  ERR_W  saturating mismatch count for the current/last run
- `fail_addr`  out  ADDR_W  address of first mismatch in run; 0 if none
- `addr`  out  ADDR_W  memory address
- `read`  out  1  memory read enable
- `write`  out  1  memory write enable
- `data_in`  out  DATA_W  memory write data
- `data_out`  in  DATA_W  memory read data, valid the cycle after `read`

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE; pattern register `pat` ∈ {CLR, ADDR, INV}.
- IDLE/DONE + `start` → WRITE, `pat`=CLR, addr=0, `err_count`/`fail_addr` cleared, `done`=0.
- WRITE: `write`=1, `read`=0, one address per cycle, 0..2**ADDR_W-1; after the last address → READ, addr wraps to 0.
- READ: `read`=1, `write`=0, one address per cycle; after the last address → DRAIN.
- DRAIN: no access; the last read is compared. Then: if `pat`≠INV, advance `pat` and go to WRITE; otherwise go to DONE.
- Pattern data: CLR = 0; ADDR = addr zero-extended (or truncated) to DATA_W; INV = bitwise ~ of ADDR.
- Check pipeline:
  - The read address and expected word are registered in the issue cycle.
  - The next cycle compares `data_out` against the registered expected word.
  - On mismatch, `err_count` increments, saturating at all-ones.
  - On the first mismatch of a run, `fail_addr` takes the registered address.
- `start` while `busy` is ignored.
- `start` in DONE restarts the run and clears the results.
- Exactly one of `write`/`read` is high in WRITE/READ; both are low in IDLE, DRAIN and DONE.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `pat`=CLR.
  - All outputs are 0: `busy`, `done`, `pass`, `err_count`, `fail_addr`, `addr`, `read`, `write`, `data_in`.
  - The compare pipeline is flushed.
- Reset mid-run aborts immediately; no pending compare is counted. Memory contents are unspecified afterwards.
- `start` sampled at edge T: `write`=1, addr=0 from T+1.
- Per pattern: 2**ADDR_W write cycles + 2**ADDR_W read cycles + 1 drain cycle = 65 cycles at default width.
- Full run is 195 cycles: `busy` high T+1..T+195, `done`=1 from T+196.
- Read latency is exactly 1 cycle. The compare for a read issued in cycle N updates `err_count` visibly at N+2.
- `pass` is combinational from `done` and `err_count`, or registered with identical timing.

## Structure
- Shared package `mem_pkg`: `ADDR_W`/`DATA_W` defaults, `bist_state_t` enum, `bist_pat_t` enum, and a function for expected data (pat, addr).
- One sub-module, `mem_bist_chk`: registered expected word and address, comparator, saturating `err_count`, first-fail capture; clear and enable inputs.
- The top holds the FSM, the address counter and the pattern register.

## Test plan
- Healthy behavioural 32x8 memory, pulse `start` → `done` at start+196, `pass`=1, `err_count`=0; addr runs 0..31 three times per direction.
- Memory with `data_out[0]` stuck-at-0 → `err_count`=32 (16 odd addresses in ADDR, 16 even in INV), `fail_addr`=0x01, `pass`=0.
- `data_out` forced 0xFF → 32 CLR errors + 32 ADDR errors saturate at 63, `fail_addr`=0x00, `pass`=0.
- `rst_n` low for one edge at run cycle 50 → next cycle all outputs 0, state IDLE; a new `start` completes with `pass`=1.
- `start` pulsed at cycles 10 and 100 of a run → no effect, still `done` at 196. `start` in DONE → `done` falls, `err_count` cleared, full rerun.
- Single-address fault (address 0x13 returns ~written data) → `err_count`=3, `fail_addr`=0x13.
